// File: rtl/button_conditioner.sv
// Pushbutton front-end: 2-flop synchroniser, debounce FSM and press/release edge pulses per channel.
// Optional long-hold pulse on btn_long is built when LONG_PRESS_EN is defined; otherwise btn_long is tied to 0.
module button_conditioner #(
  parameter int N_BTN    = 2,
  parameter int DB_CYC   = 1000000,
  parameter int LONG_CYC = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  // state        | meaning
  // RELEASED     | debounced level 0, waiting for s2=1
  // PRESS_WAIT   | s2=1, counting stable cycles before accepting a press
  // HELD         | debounced level 1, waiting for s2=0
  // RELEASE_WAIT | s2=0, counting stable cycles before accepting a release
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

`ifdef LONG_PRESS_EN
  localparam int HW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
`endif

  if (DB_CYC < 2 || LONG_CYC < 2) begin : g_param_check
    $error("button_conditioner: DB_CYC and LONG_CYC must both be >= 2");
  end

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Every transition restarts cnt, so a count never carries across states.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync2[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync2[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef LONG_PRESS_EN
    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // fired keeps the saturated counter from pulsing again within one press.
    always_comb begin
      hold_d  = hold_q;
      fired_d = fired_q;
      long_d  = 1'b0;
      if (state_q == PRESS_WAIT && state_d == HELD) begin
        hold_d  = '0;
        fired_d = 1'b0;
      end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
        if (hold_q == HOLD_LAST) begin
          if (!fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end else begin
        hold_d  = '0;
        fired_d = 1'b0;
      end
      if (state_d == RELEASED) begin
        hold_d  = '0;
        fired_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q  <= '0;
        fired_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        fired_q <= fired_d;
        long_q  <= long_d;
      end
    end

    assign btn_long[i] = long_q;
`else
    assign btn_long[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random stimulus against a window-based model.
module tb_button_conditioner;
  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LC = 20;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(.N_BTN(N), .DB_CYC(DB), .LONG_CYC(LC)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  // Model: a level change is accepted once the last DB+1 synchronised samples all disagree with it.
  logic [N-1:0] m_p1, m_p2;
  logic [DB:0]  m_hist [N];
  logic [N-1:0] m_level, m_press, m_release, m_long;
  int           m_t [N];

  always @(posedge clk) begin : model
    logic [N-1:0] x;
    if (reset) begin
      m_p1 = '0; m_p2 = '0;
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      for (int c = 0; c < N; c++) begin
        m_hist[c] = '0;
        m_t[c]    = 0;
      end
    end else begin
      x    = m_p2;
      m_p2 = m_p1;
      m_p1 = btn_in;
      m_press = '0; m_release = '0; m_long = '0;
      for (int c = 0; c < N; c++) begin
        m_hist[c] = {m_hist[c][DB-1:0], x[c]};
        if (LONG_EN && m_level[c]) begin
          m_t[c] = m_t[c] + 1;
          if (m_t[c] == LC) m_long[c] = 1'b1;
        end
        if (!m_level[c] && (&m_hist[c])) begin
          m_level[c] = 1'b1;
          m_press[c] = 1'b1;
          m_t[c]     = 0;
        end else if (m_level[c] && m_hist[c] == '0) begin
          m_level[c]   = 1'b0;
          m_release[c] = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] b, input logic r);
    btn_in = b;
    reset  = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 1; i <= 3; i++) begin
      cyc('0, 1'b1);
      n_vec++;
      if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0", i,
                 {btn_level, btn_press, btn_release, btn_long});
      end
    end
    for (int i = 1; i <= 8; i++) begin
      cyc('0, 1'b0);
      n_vec++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_release, m_long}) begin
        n_err++;
        $display("FAIL reset_idle_model cyc=%0d got=%h want=%h", i,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_release, m_long});
      end
    end
  endtask

  task automatic test_clean_press;
    for (int i = 1; i <= 12; i++) begin
      cyc(2'b01, 1'b0);
      n_vec++;
      if (btn_press !== {1'b0, i == 7} || btn_level !== {1'b0, i >= 7} || btn_release !== 2'b00) begin
        n_err++;
        $display("FAIL clean_press cyc=%0d got p=%b l=%b r=%b want p=%b l=%b r=00", i,
                 btn_press, btn_level, btn_release, {1'b0, i == 7}, {1'b0, i >= 7});
      end
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(2'b00, 1'b0);
      n_vec++;
      if (btn_release !== {1'b0, i == 7} || btn_level !== {1'b0, i < 7} || btn_press !== 2'b00) begin
        n_err++;
        $display("FAIL clean_release cyc=%0d got r=%b l=%b p=%b want r=%b l=%b p=00", i,
                 btn_release, btn_level, btn_press, {1'b0, i == 7}, {1'b0, i < 7});
      end
    end
  endtask

  task automatic test_press_bounce;
    logic [13:0] seq;
    seq = 14'b00000000110110;
    for (int i = 0; i < 14; i++) begin
      cyc({1'b0, seq[i]}, 1'b0);
      n_vec++;
      if ({btn_press, btn_level, btn_release} !== 6'b0) begin
        n_err++;
        $display("FAIL press_bounce cyc=%0d got p=%b l=%b r=%b want all 0", i,
                 btn_press, btn_level, btn_release);
      end
    end
  endtask

  task automatic test_release_bounce;
    int n_rel;
    n_rel = 0;
    idle(10);
    for (int i = 1; i <= 10; i++) cyc(2'b01, 1'b0);
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);
    cyc(2'b01, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      cyc(2'b00, 1'b0);
      if (btn_release[0]) n_rel++;
      n_vec++;
      if (btn_release !== {1'b0, j == 7} || btn_press !== 2'b00) begin
        n_err++;
        $display("FAIL release_bounce cyc=%0d got r=%b p=%b want r=%b p=00", j,
                 btn_release, btn_press, {1'b0, j == 7});
      end
    end
    n_vec++;
    if (n_rel !== 1) begin
      n_err++;
      $display("FAIL release_bounce_count got=%0d want=1", n_rel);
    end
  endtask

  task automatic test_independent;
    idle(10);
    for (int i = 1; i <= 10; i++) begin
      cyc(2'b11, 1'b0);
      n_vec++;
      if (btn_press !== (i == 7 ? 2'b11 : 2'b00)) begin
        n_err++;
        $display("FAIL indep_press cyc=%0d got=%b want=%b", i, btn_press, (i == 7 ? 2'b11 : 2'b00));
      end
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(2'b01, 1'b0);
      n_vec++;
      if (btn_release !== (i == 7 ? 2'b10 : 2'b00) || btn_level !== (i >= 7 ? 2'b01 : 2'b11)) begin
        n_err++;
        $display("FAIL indep_release cyc=%0d got r=%b l=%b want r=%b l=%b", i, btn_release, btn_level,
                 (i == 7 ? 2'b10 : 2'b00), (i >= 7 ? 2'b01 : 2'b11));
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    idle(10);
    for (int i = 1; i <= 10; i++) cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b1);
    n_vec++;
    if (btn_level !== 2'b00 || btn_press !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_hold_clear got l=%b p=%b want 00 00", btn_level, btn_press);
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(2'b01, 1'b0);
      n_vec++;
      if (btn_press !== {1'b0, i == 7} || btn_level !== {1'b0, i >= 7}) begin
        n_err++;
        $display("FAIL reset_mid_hold_repress cyc=%0d got p=%b l=%b want p=%b l=%b", i,
                 btn_press, btn_level, {1'b0, i == 7}, {1'b0, i >= 7});
      end
    end
  endtask

  task automatic test_long_press;
    int n_long, p_at, l_at;
    n_long = 0; p_at = -1; l_at = -1;
    idle(12);
    for (int i = 1; i <= 40; i++) begin
      cyc(2'b01, 1'b0);
      if (btn_press[0]) p_at = i;
      if (btn_long[0]) begin
        n_long++;
        l_at = i;
      end
      n_vec++;
      if (btn_long !== m_long || btn_press !== m_press) begin
        n_err++;
        $display("FAIL long_model cyc=%0d got lg=%b p=%b want lg=%b p=%b", i, btn_long, btn_press, m_long, m_press);
      end
    end
    n_vec++;
    if (LONG_EN) begin
      if (n_long !== 1 || p_at !== 7 || l_at - p_at !== LC) begin
        n_err++;
        $display("FAIL long_pulse got n=%0d press_at=%0d long_at=%0d want n=1 press_at=7 long_at=%0d",
                 n_long, p_at, l_at, 7 + LC);
      end
    end else begin
      if (n_long !== 0) begin
        n_err++;
        $display("FAIL long_disabled got n=%0d want=0", n_long);
      end
    end
    idle(12);
  endtask

  task automatic test_random;
    logic [N-1:0] b;
    logic         r;
    b = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
      r = ($urandom_range(0, 299) == 0);
      cyc(b, r);
      n_vec++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_release, m_long}
          || (btn_press & btn_release) !== '0) begin
        n_err++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", i,
                 {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_release, m_long});
      end
    end
  endtask

  initial begin
    btn_in = '0;
    reset  = 1'b1;
    test_reset;
    test_clean_press;
    test_press_bounce;
    test_release_bounce;
    test_independent;
    test_reset_mid_hold;
    test_long_press;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
